// File: rtl/video_types.sv
`default_nettype none
// ============================================================================
// Package     : video_types
// Description : Constants and types shared by the video-side blocks: the DMA
//               register location, OAM location and size, the OAM DMA state
//               encoding, and the echo-RAM page remap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package video_types;

  // CPU address of the OAM DMA source-page register.
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  // Absolute location of the OAM table on the bus.
  localparam logic [15:0] OAM_LOC  = 16'hFE00;
  localparam logic [15:0] OAM_BASE = OAM_LOC;

  // 40 sprites x 4 bytes.
  localparam int OAM_SIZE = 160;

  // OAM DMA sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DRAIN = 3'd4
  } dma_state_t;

  // Pages 0xE0..0xFF are the echo-RAM mirror of 0xC0..0xDF; fold them back
  // onto the real work RAM. Every other page is fetched as written.
  function automatic logic [7:0] remap_page(input logic [7:0] page);
    if (page >= 8'hE0) begin
      return page - 8'h20;
    end
    return page;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_controller
// Description : OAM DMA bus master. A CPU write of a page number to the DMA
//               register copies OAM_SIZE bytes from {page,8'h00} onward into
//               OAM, one byte per read/write round trip, with busy asserted
//               for the whole transfer so the CPU arbiter can stall the CPU.
//
// Ports       : clk, reset             - clock, async active-high reset
//               reg_wr/reg_rd/reg_addr - CPU register access strobes/address
//               reg_wdata/reg_rdata    - CPU write data / registered readback
//               reg_hit                - registered DMA register decode
//               mem_req/mem_addr       - source read request, held until gnt
//               mem_gnt                - source request accepted
//               mem_rvalid/mem_rdata   - source read data return
//               oam_we/oam_addr/oam_wdata - one-cycle OAM write port
//               busy                   - transfer in progress
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = video_types::DMA_REG_ADDR,
  parameter int          OAM_SIZE     = video_types::OAM_SIZE,
  parameter logic [15:0] OAM_BASE     = video_types::OAM_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        reg_hit,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic        oam_we,
  output logic [15:0] oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        busy
);

  import video_types::*;

  localparam logic [7:0] c_last_index = 8'(OAM_SIZE - 1);

  dma_state_t  r_state;
  dma_state_t  w_next_state;
  logic [7:0]  r_index;
  logic [7:0]  w_next_index;
  logic [7:0]  r_src_page;
  logic [7:0]  r_data;
  logic        w_capture;
  logic        r_busy;
  logic        r_reg_hit;
  logic [7:0]  r_reg_rdata;

  logic        w_reg_sel;
  logic        w_start;
  logic        w_last;
  logic [7:0]  w_eff_page;

  assign w_reg_sel  = (reg_addr == DMA_REG_ADDR);
  assign w_start    = reg_wr && w_reg_sel;
  assign w_last     = (r_index == c_last_index);
  assign w_eff_page = remap_page(r_src_page);

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_index <= 8'h00;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_index <= w_next_index;
      r_busy  <= (w_next_state != IDLE);
      if (w_capture) begin
        r_data <= mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // CPU register: source page, decode flag and readback
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_page  <= 8'h00;
      r_reg_hit   <= 1'b0;
      r_reg_rdata <= 8'h00;
    end else begin
      r_reg_hit   <= (reg_wr || reg_rd) && w_reg_sel;
      r_reg_rdata <= (reg_rd && w_reg_sel) ? r_src_page : 8'h00;
      if (w_start) begin
        r_src_page <= reg_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_index = r_index;
    w_capture    = 1'b0;

    case (r_state)
      IDLE: begin
        w_next_index = 8'h00;
        if (w_start) begin
          w_next_state = REQ;
        end
      end

      REQ: begin
        if (w_start) begin
          w_next_index = 8'h00;
          // A read granted in this same cycle will still return data; it
          // belongs to the old page, so it is drained rather than captured.
          w_next_state = mem_gnt ? DRAIN : REQ;
        end else if (mem_gnt) begin
          w_next_state = WAIT;
        end
      end

      WAIT: begin
        if (w_start) begin
          w_next_index = 8'h00;
          // If the old data arrives in the restart cycle it is simply not
          // captured; otherwise it is still in flight and must be drained.
          w_next_state = mem_rvalid ? REQ : DRAIN;
        end else if (mem_rvalid) begin
          w_capture    = 1'b1;
          w_next_state = WRITE;
        end
      end

      WRITE: begin
        // The OAM write of this cycle always goes out; a restart only
        // changes where the sequencer goes afterwards.
        if (w_start) begin
          w_next_index = 8'h00;
          w_next_state = REQ;
        end else if (w_last) begin
          w_next_index = 8'h00;
          w_next_state = IDLE;
        end else begin
          w_next_index = r_index + 8'h01;
          w_next_state = REQ;
        end
      end

      DRAIN: begin
        w_next_index = 8'h00;
        if (mem_rvalid) begin
          w_next_state = REQ;
        end
      end

      default: begin
        w_next_index = 8'h00;
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded straight from the state register, so an async reset
  // clears every bus output immediately.
  // --------------------------------------------------------------------------
  assign mem_req   = (r_state == REQ);
  assign mem_addr  = mem_req ? {w_eff_page, r_index} : 16'h0000;
  assign oam_we    = (r_state == WRITE);
  assign oam_addr  = oam_we ? (OAM_BASE + {8'h00, r_index}) : 16'h0000;
  assign oam_wdata = oam_we ? r_data : 8'h00;
  assign busy      = r_busy;
  assign reg_hit   = r_reg_hit;
  assign reg_rdata = r_reg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma_controller
// Description : Directed self-checking bench for oam_dma_controller with a
//               source memory model whose byte at address A is A[7:0]^0x5A.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_wr, reg_rd;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        reg_hit;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        oam_we;
  logic [15:0] oam_addr;
  logic [7:0]  oam_wdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  oam_dma_controller dut (
    .clk        (clk),
    .reset      (reset),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_hit    (reg_hit),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .oam_we     (oam_we),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .busy       (busy)
  );

  // --------------------------------------------------------------------------
  // Source memory model: grant after gnt latency, data after rvalid latency
  // --------------------------------------------------------------------------
  int          gnt_cnt = 0;
  int          rv_cnt = 0;
  logic        pending = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  int          gnt_lat_r = 0;
  int          rv_lat_r = 0;
  int          fix_gnt = 0;
  int          fix_rv = 0;
  bit          rnd = 1'b0;

  always_comb begin
    mem_gnt    = mem_req && (gnt_cnt == (rnd ? gnt_lat_r : fix_gnt));
    mem_rvalid = pending && (rv_cnt == (rnd ? rv_lat_r : fix_rv));
    mem_rdata  = mem_rvalid ? (pend_addr[7:0] ^ 8'h5A) : 8'hEE;
  end

  always @(posedge clk) begin
    if (reset) begin
      gnt_cnt <= 0;
      rv_cnt  <= 0;
      pending <= 1'b0;
    end else begin
      if (mem_gnt) begin
        gnt_cnt   <= 0;
        pending   <= 1'b1;
        rv_cnt    <= 0;
        pend_addr <= mem_addr;
        rv_lat_r  <= int'($urandom_range(0, 5));
        gnt_lat_r <= int'($urandom_range(0, 5));
      end else begin
        gnt_cnt <= mem_req ? gnt_cnt + 1 : 0;
        if (pending) begin
          if (mem_rvalid) pending <= 1'b0;
          else            rv_cnt  <= rv_cnt + 1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bus monitor: logs every OAM write and counts protocol violations
  // --------------------------------------------------------------------------
  int          wr_cnt = 0;
  int          order_err = 0;
  int          nowr_err = 0;
  int          stab_err = 0;
  int          range_err = 0;
  int          prev_idx = -1;
  bit          rv_seen = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  logic [15:0] rng_lo = 16'h0000;
  logic [15:0] rng_hi = 16'hFFFF;
  logic [15:0] wlog_addr [0:2047];
  logic [7:0]  wlog_data [0:2047];

  always @(negedge clk) begin
    if (oam_we) begin
      int idx;
      idx = int'(oam_addr) - 32'hFE00;
      if (idx < 0 || idx > 159) order_err++;
      else if (idx != prev_idx + 1 && idx != 0) order_err++;
      prev_idx = idx;
      if (!rv_seen) nowr_err++;
      rv_seen = 1'b0;
      if (wr_cnt < 2048) begin
        wlog_addr[wr_cnt] = oam_addr;
        wlog_data[wr_cnt] = oam_wdata;
      end
      wr_cnt++;
    end
    if (mem_rvalid) rv_seen = 1'b1;
    if (mem_req && (mem_addr < rng_lo || mem_addr > rng_hi)) range_err++;
    if (prev_req && !prev_gnt && mem_req && mem_addr != prev_addr) stab_err++;
    prev_req  = mem_req;
    prev_gnt  = mem_gnt;
    prev_addr = mem_addr;
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output logic hit);
    reg_wr    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    hit       = reg_hit;
    reg_wr    = 1'b0;
    reg_addr  = 16'h0000;
    reg_wdata = 8'h00;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic hit, output logic [7:0] d);
    reg_rd   = 1'b1;
    reg_addr = a;
    @(negedge clk);
    hit      = reg_hit;
    d        = reg_rdata;
    reg_rd   = 1'b0;
    reg_addr = 16'h0000;
  endtask

  task automatic wait_idle(input int max, output int cycles, output bit to);
    cycles = 0;
    while (busy && cycles < max) begin
      cycles++;
      @(negedge clk);
    end
    to = busy;
  endtask

  // Number of bad entries among 160 logged writes starting at base: each OAM
  // index must be written exactly once with byte index^0x5A.
  function automatic int log_bad(input int base);
    bit seen [0:159];
    int bad = 0;
    for (int i = 0; i < 160; i++) seen[i] = 1'b0;
    for (int k = base; k < base + 160; k++) begin
      int idx;
      idx = int'(wlog_addr[k]) - 32'hFE00;
      if (idx < 0 || idx > 159) bad++;
      else begin
        if (seen[idx] || wlog_data[k] !== (8'(idx) ^ 8'h5A)) bad++;
        seen[idx] = 1'b1;
      end
    end
    return bad;
  endfunction

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    logic       hit;
    logic [7:0] rd;
    int         cyc, base, b_ord, b_nowr, b_stab, b_rng, n;
    bit         to;

    reset = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 16'h0; reg_wdata = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mem_req", {15'h0, mem_req, mem_addr}, 32'h0);
    check("rst_oam", {7'h0, oam_we, oam_addr, oam_wdata}, 32'h0);
    check("rst_reg", {22'h0, reg_hit, reg_rdata}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // ---- zero-wait transfer from 0xC0 ----
    base = wr_cnt; b_ord = order_err; b_nowr = nowr_err;
    cpu_write(16'hFF46, 8'hC0, hit);
    check("wr_hit", 32'(hit), 32'h1);
    wait_idle(5000, cyc, to);
    check("c0_busy_cycles", cyc, 480);
    check("c0_writes", wr_cnt - base, 160);
    check("c0_first_addr", 32'(wlog_addr[base]), 32'hFE00);
    check("c0_first_data", 32'(wlog_data[base]), 32'h5A);
    check("c0_last_addr", 32'(wlog_addr[base + 159]), 32'hFE9F);
    check("c0_last_data", 32'(wlog_data[base + 159]), 32'(8'h9F ^ 8'h5A));
    check("c0_image", log_bad(base), 0);
    check("c0_order", order_err - b_ord, 0);
    check("c0_rvalid_before_we", nowr_err - b_nowr, 0);
    cpu_read(16'hFF46, hit, rd);
    check("rd_hit", 32'(hit), 32'h1);
    check("rd_data_c0", 32'(rd), 32'hC0);

    // ---- echo page 0xE1 reads 0xC1xx ----
    rng_lo = 16'hC100; rng_hi = 16'hC19F;
    base = wr_cnt; b_rng = range_err;
    cpu_write(16'hFF46, 8'hE1, hit);
    wait_idle(5000, cyc, to);
    check("e1_busy_cycles", cyc, 480);
    check("e1_writes", wr_cnt - base, 160);
    check("e1_addr_range", range_err - b_rng, 0);
    check("e1_image", log_bad(base), 0);
    cpu_read(16'hFF46, hit, rd);
    check("rd_data_e1", 32'(rd), 32'hE1);

    // ---- random 0-5 cycle grant / data latency ----
    rnd = 1'b1;
    rng_lo = 16'hC300; rng_hi = 16'hC39F;
    base = wr_cnt; b_ord = order_err; b_nowr = nowr_err; b_stab = stab_err; b_rng = range_err;
    cpu_write(16'hFF46, 8'hC3, hit);
    wait_idle(5000, cyc, to);
    check("rnd_timeout", 32'(to), 32'h0);
    check("rnd_writes", wr_cnt - base, 160);
    check("rnd_image", log_bad(base), 0);
    check("rnd_addr_stable", stab_err - b_stab, 0);
    check("rnd_rvalid_before_we", nowr_err - b_nowr, 0);
    check("rnd_order", order_err - b_ord, 0);
    check("rnd_addr_range", range_err - b_rng, 0);
    rnd = 1'b0;

    // ---- restart at index 37 while waiting for data ----
    fix_gnt = 0; fix_rv = 3;
    rng_lo = 16'h0000; rng_hi = 16'hFFFF;
    cpu_write(16'hFF46, 8'hC0, hit);
    n = 0;
    while (!(mem_gnt && mem_addr == 16'hC025) && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("rs_reach_idx37", 32'(n < 2000), 32'h1);
    @(negedge clk);
    base = wr_cnt;
    check("rs_writes_before", base > 0 ? 32'(wlog_addr[base - 1]) : 32'h0, 32'hFE24);
    cpu_write(16'hFF46, 8'hD0, hit);
    rng_lo = 16'hD000; rng_hi = 16'hD09F; b_rng = range_err;
    wait_idle(5000, cyc, to);
    check("rs_timeout", 32'(to), 32'h0);
    check("rs_next_addr", 32'(wlog_addr[base]), 32'hFE00);
    check("rs_next_data", 32'(wlog_data[base]), 32'h5A);
    check("rs_writes", wr_cnt - base, 160);
    check("rs_image", log_bad(base), 0);
    check("rs_addr_range", range_err - b_rng, 0);
    rng_lo = 16'h0000; rng_hi = 16'hFFFF;
    fix_rv = 0;

    // ---- restart coinciding with the final write ----
    base = wr_cnt;
    cpu_write(16'hFF46, 8'hC0, hit);
    n = 0;
    while (!(oam_we && oam_addr == 16'hFE9F) && n < 2000) begin
      n++;
      @(negedge clk);
    end
    cpu_write(16'hFF46, 8'hC4, hit);
    check("fin_busy_held", 32'(busy), 32'h1);
    wait_idle(5000, cyc, to);
    check("fin_writes", wr_cnt - base, 320);
    check("fin_first_image", log_bad(base), 0);
    check("fin_second_image", log_bad(base + 160), 0);

    // ---- async reset at index 80 in REQ ----
    fix_gnt = 3;
    base = wr_cnt;
    cpu_write(16'hFF46, 8'hC0, hit);
    n = 0;
    while (!(mem_req && mem_addr == 16'hC050) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("ar_reach_idx80", 32'(n < 3000), 32'h1);
    check("ar_busy_before", 32'(busy), 32'h1);
    check("ar_writes_before", wr_cnt - base, 80);
    #1 reset = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_mem", {15'h0, mem_req, mem_addr}, 32'h0);
    check("ar_oam", {7'h0, oam_we, oam_addr, oam_wdata}, 32'h0);
    base = wr_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("ar_no_more_writes", wr_cnt - base, 0);
    check("ar_idle", {30'h0, busy, mem_req}, 32'h0);
    cpu_read(16'hFF46, hit, rd);
    check("ar_page_cleared", 32'(rd), 32'h00);
    fix_gnt = 0;
    base = wr_cnt;
    cpu_write(16'hFF46, 8'hC0, hit);
    wait_idle(5000, cyc, to);
    check("ar_clean_busy", cyc, 480);
    check("ar_clean_writes", wr_cnt - base, 160);
    check("ar_clean_image", log_bad(base), 0);

    // ---- neighbouring addresses are ignored ----
    cpu_write(16'hFF47, 8'h55, hit);
    check("ff47_hit", 32'(hit), 32'h0);
    repeat (5) @(negedge clk);
    check("ff47_no_start", {30'h0, busy, mem_req}, 32'h0);
    cpu_read(16'hFF45, hit, rd);
    check("ff45_hit", 32'(hit), 32'h0);
    check("ff45_rdata", 32'(rd), 32'h00);
    cpu_read(16'hFF46, hit, rd);
    check("ff46_unchanged", 32'(rd), 32'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
